// File: rtl/kv_wr_slot_sink_if.sv
// kv_wr_slot_sink_if: key-vault write, lock, zeroize and read bundle between kv writers/consumers and the slot sink
interface kv_wr_slot_sink_if #(
  parameter int NUM_ENTRIES  = 24,
  parameter int ENTRY_DWORDS = 16
);
  localparam int EW = $clog2(NUM_ENTRIES);
  localparam int OW = $clog2(ENTRY_DWORDS);
  logic                   kv_wr_en;
  logic [EW-1:0]          kv_wr_entry;
  logic [OW-1:0]          kv_wr_offset;
  logic [31:0]            kv_wr_data;
  logic                   kv_wr_err;
  logic [NUM_ENTRIES-1:0] lock_wr;
  logic                   clear_req;
  logic                   busy;
  logic                   rd_en;
  logic [EW-1:0]          rd_entry;
  logic [OW-1:0]          rd_offset;
  logic                   rd_valid;
  logic [31:0]            rd_data;
  logic                   rd_err;
  logic [NUM_ENTRIES-1:0] entry_valid;
  modport master (
    output kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, lock_wr, clear_req, rd_en, rd_entry, rd_offset,
    input  kv_wr_err, busy, rd_valid, rd_data, rd_err, entry_valid
  );
  modport slave (
    input  kv_wr_en, kv_wr_entry, kv_wr_offset, kv_wr_data, lock_wr, clear_req, rd_en, rd_entry, rd_offset,
    output kv_wr_err, busy, rd_valid, rd_data, rd_err, entry_valid
  );
endinterface

// File: rtl/kv_wr_slot_sink.sv
// kv_wr_slot_sink: in-order write-once key entries with 1-cycle read port and zeroize sweep; optional per-dword parity via KV_WR_SINK_PARITY_EN
module kv_wr_slot_sink #(
  parameter int NUM_ENTRIES  = 24,
  parameter int ENTRY_DWORDS = 16
) (
  input logic clk,
  input logic reset_n,
  kv_wr_slot_sink_if.slave bus
);
  localparam int EW = $clog2(NUM_ENTRIES);
  localparam int OW = $clog2(ENTRY_DWORDS);
  localparam logic [EW:0]   NE     = (EW+1)'(NUM_ENTRIES);
  localparam logic [EW-1:0] LAST_E = EW'(NUM_ENTRIES - 1);
  localparam logic [OW-1:0] LAST_O = OW'(ENTRY_DWORDS - 1);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;
  logic [31:0]            mem [NUM_ENTRIES][ENTRY_DWORDS];
  logic [OW:0]            wr_ptr [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] complete, poison;
  logic [0:0]             state;
  logic [EW-1:0]          clr_idx;
  logic                   idle, wr_open, accept, mismatch, rd_ok, par_bad;
  logic [EW-1:0]          we, re;
  logic [OW-1:0]          wo, ro;
`ifdef KV_WR_SINK_PARITY_EN
  logic                   par [NUM_ENTRIES][ENTRY_DWORDS];
`endif
  assign we = bus.kv_wr_entry;
  assign wo = bus.kv_wr_offset;
  assign re = bus.rd_entry;
  assign ro = bus.rd_offset;
  assign idle = state == IDLE;
  assign bus.busy = state == CLEARING;
  assign bus.entry_valid = complete & ~poison;
  // write qualification and read legality, all against pre-edge state
  always_comb begin
    wr_open  = bus.kv_wr_en && idle && !bus.clear_req && ({1'b0, we} < NE) &&
               !bus.lock_wr[we] && !complete[we] && !poison[we];
    accept   = wr_open && ({1'b0, wo} == wr_ptr[we]);
    mismatch = wr_open && !accept;
    rd_ok    = bus.rd_en && idle && ({1'b0, re} < NE) && complete[re] && !poison[re];
`ifdef KV_WR_SINK_PARITY_EN
    par_bad  = rd_ok && ((^mem[re][ro]) != par[re][ro]);
`else
    par_bad  = 1'b0;
`endif
  end
  // sweep sequencer: clear_req (re)starts at index 0, one entry per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_idx <= '0;
    end else if (bus.clear_req) begin
      state   <= CLEARING;
      clr_idx <= '0;
    end else if (state == CLEARING) begin
      state   <= (clr_idx == LAST_E) ? IDLE : CLEARING;
      clr_idx <= (clr_idx == LAST_E) ? '0 : clr_idx + 1'b1;
    end
  end
  // entry storage and fill tracking; sweep and writes never coincide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        for (int d = 0; d < ENTRY_DWORDS; d++) begin
          mem[i][d] <= '0;
`ifdef KV_WR_SINK_PARITY_EN
          par[i][d] <= 1'b0;
`endif
        end
        wr_ptr[i] <= '0;
      end
      complete <= '0;
      poison   <= '0;
    end else begin
      if (state == CLEARING) begin
        for (int d = 0; d < ENTRY_DWORDS; d++) begin
          mem[clr_idx][d] <= '0;
`ifdef KV_WR_SINK_PARITY_EN
          par[clr_idx][d] <= 1'b0;
`endif
        end
        wr_ptr[clr_idx]   <= '0;
        complete[clr_idx] <= 1'b0;
        poison[clr_idx]   <= 1'b0;
      end
      if (accept) begin
        mem[we][wo] <= bus.kv_wr_data;
`ifdef KV_WR_SINK_PARITY_EN
        par[we][wo] <= ^bus.kv_wr_data;
`endif
        wr_ptr[we] <= wr_ptr[we] + 1'b1;
        if (wo == LAST_O) complete[we] <= 1'b1;
      end
      if (mismatch) poison[we] <= 1'b1;
      if (par_bad) poison[re] <= 1'b1;
    end
  end
  // registered error pulse and read response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.kv_wr_err <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_err    <= 1'b0;
      bus.rd_data   <= '0;
    end else begin
      bus.kv_wr_err <= bus.kv_wr_en && !accept;
      bus.rd_valid  <= bus.rd_en;
      bus.rd_err    <= bus.rd_en && (!rd_ok || par_bad);
      bus.rd_data   <= (rd_ok && !par_bad) ? mem[re][ro] : '0;
    end
  end
endmodule

// File: tb/tb_kv_wr_slot_sink.sv
// tb_kv_wr_slot_sink: directed scenarios for the key-vault write sink
module tb_kv_wr_slot_sink;
  logic clk = 1'b0;
  logic reset_n;
  int n_cmp = 0;
  int n_bad = 0;
  logic werr, rv, rerr;
  logic [31:0] rdat;
  kv_wr_slot_sink_if #(.NUM_ENTRIES(24), .ENTRY_DWORDS(16)) bus();
  kv_wr_slot_sink #(.NUM_ENTRIES(24), .ENTRY_DWORDS(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] e, input logic [3:0] o, input logic [31:0] d);
    bus.kv_wr_en = 1'b1;
    bus.kv_wr_entry = e;
    bus.kv_wr_offset = o;
    bus.kv_wr_data = d;
    tick();
    bus.kv_wr_en = 1'b0;
    werr = bus.kv_wr_err;
  endtask

  task automatic rd(input logic [4:0] e, input logic [3:0] o);
    bus.rd_en = 1'b1;
    bus.rd_entry = e;
    bus.rd_offset = o;
    tick();
    bus.rd_en = 1'b0;
    rv = bus.rd_valid;
    rerr = bus.rd_err;
    rdat = bus.rd_data;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    n_cmp++; if (bus.entry_valid !== 24'h0) begin n_bad++; $display("FAIL reset_entry_valid got %h exp 0", bus.entry_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if ({bus.kv_wr_err, bus.rd_valid, bus.rd_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {bus.kv_wr_err, bus.rd_valid, bus.rd_err}); end
    n_cmp++; if (bus.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fill;
    int errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        n_cmp++; if (bus.entry_valid[3] !== 1'b0) begin n_bad++; $display("FAIL fill_valid_early got %b exp 0", bus.entry_valid[3]); end
      end
      wr(5'd3, 4'(i), 32'hA000_0000 + 32'(i));
      errs += int'(werr);
    end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL fill_errs got %0d exp 0", errs); end
    n_cmp++; if (bus.entry_valid[3] !== 1'b1) begin n_bad++; $display("FAIL fill_valid got %b exp 1", bus.entry_valid[3]); end
    rd(5'd3, 4'd5);
    n_cmp++; if ({rv, rerr} !== 2'b10) begin n_bad++; $display("FAIL fill_rd_flags got %b exp 10", {rv, rerr}); end
    n_cmp++; if (rdat !== 32'hA000_0005) begin n_bad++; $display("FAIL fill_rd_data got %h exp a0000005", rdat); end
    tick();
    n_cmp++; if ({bus.rd_valid, bus.rd_data} !== 33'h0) begin n_bad++; $display("FAIL idle_rd got %b/%h exp 0/0", bus.rd_valid, bus.rd_data); end
  endtask

  task automatic test_poison;
    wr(5'd7, 4'd0, 32'h7);
    n_cmp++; if (werr !== 1'b0) begin n_bad++; $display("FAIL poison_first_err got %b exp 0", werr); end
    wr(5'd7, 4'd2, 32'h72);
    n_cmp++; if (werr !== 1'b1) begin n_bad++; $display("FAIL poison_skip_err got %b exp 1", werr); end
    tick();
    n_cmp++; if (bus.kv_wr_err !== 1'b0) begin n_bad++; $display("FAIL poison_err_pulse got %b exp 0", bus.kv_wr_err); end
    n_cmp++; if (bus.entry_valid[7] !== 1'b0) begin n_bad++; $display("FAIL poison_valid got %b exp 0", bus.entry_valid[7]); end
    wr(5'd7, 4'd1, 32'h71);
    n_cmp++; if (werr !== 1'b1) begin n_bad++; $display("FAIL poison_next_err got %b exp 1", werr); end
    rd(5'd7, 4'd0);
    n_cmp++; if ({rv, rerr, rdat} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL poison_rd got %b%b/%h exp 11/0", rv, rerr, rdat); end
  endtask

  task automatic test_lock;
    bus.lock_wr[2] = 1'b1;
    wr(5'd2, 4'd0, 32'h20);
    n_cmp++; if (werr !== 1'b1) begin n_bad++; $display("FAIL lock_err got %b exp 1", werr); end
    bus.lock_wr[2] = 1'b0;
    wr(5'd2, 4'd0, 32'h20);
    n_cmp++; if (werr !== 1'b0) begin n_bad++; $display("FAIL unlock_wr0 got %b exp 0", werr); end
    wr(5'd2, 4'd1, 32'h21);
    n_cmp++; if (werr !== 1'b0) begin n_bad++; $display("FAIL unlock_wr1 got %b exp 0", werr); end
  endtask

  task automatic test_range;
    wr(5'd24, 4'd0, 32'hDEAD);
    n_cmp++; if (werr !== 1'b1) begin n_bad++; $display("FAIL range_wr_err got %b exp 1", werr); end
    rd(5'd31, 4'd0);
    n_cmp++; if ({rv, rerr, rdat} !== {2'b11, 32'h0}) begin n_bad++; $display("FAIL range_rd got %b%b/%h exp 11/0", rv, rerr, rdat); end
    n_cmp++; if (bus.entry_valid !== 24'h000008) begin n_bad++; $display("FAIL range_valid got %h exp 000008", bus.entry_valid); end
  endtask

  task automatic test_rewrite;
    wr(5'd3, 4'd0, 32'hBAD);
    n_cmp++; if (werr !== 1'b1) begin n_bad++; $display("FAIL rewrite_err got %b exp 1", werr); end
    rd(5'd3, 4'd0);
    n_cmp++; if ({rerr, rdat} !== {1'b0, 32'hA000_0000}) begin n_bad++; $display("FAIL rewrite_rd got %b/%h exp 0/a0000000", rerr, rdat); end
  endtask

  task automatic test_same_cycle;
    for (int i = 0; i < 15; i++) wr(5'd5, 4'(i), 32'h5000 + 32'(i));
    bus.kv_wr_en = 1'b1; bus.kv_wr_entry = 5'd5; bus.kv_wr_offset = 4'd15; bus.kv_wr_data = 32'h500F;
    bus.rd_en = 1'b1; bus.rd_entry = 5'd5; bus.rd_offset = 4'd15;
    tick();
    bus.kv_wr_en = 1'b0; bus.rd_en = 1'b0;
    n_cmp++; if ({bus.kv_wr_err, bus.rd_err, bus.rd_data} !== {2'b01, 32'h0}) begin n_bad++; $display("FAIL same_cycle got %b%b/%h exp 01/0", bus.kv_wr_err, bus.rd_err, bus.rd_data); end
    rd(5'd5, 4'd15);
    n_cmp++; if ({rerr, rdat} !== {1'b0, 32'h500F}) begin n_bad++; $display("FAIL same_cycle_after got %b/%h exp 0/500f", rerr, rdat); end
  endtask

  task automatic test_back_to_back;
    bus.rd_en = 1'b1;
    bus.rd_entry = 5'd3;
    for (int i = 0; i < 4; i++) begin
      bus.rd_offset = 4'(i + 8);
      tick();
      n_cmp++; if ({bus.rd_valid, bus.rd_err, bus.rd_data} !== {2'b10, 32'hA000_0008 + 32'(i)}) begin n_bad++; $display("FAIL b2b_%0d got %b%b/%h exp 10/%h", i, bus.rd_valid, bus.rd_err, bus.rd_data, 32'hA000_0008 + 32'(i)); end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_clear;
    int cnt = 0;
    logic w_during = 1'b0, r_during = 1'b0;
    for (int i = 0; i < 16; i++) wr(5'd0, 4'(i), 32'hC0 + 32'(i));
    n_cmp++; if (bus.entry_valid !== 24'h000029) begin n_bad++; $display("FAIL clear_pre_valid got %h exp 000029", bus.entry_valid); end
    bus.clear_req = 1'b1;
    bus.kv_wr_en = 1'b1; bus.kv_wr_entry = 5'd1; bus.kv_wr_offset = 4'd0; bus.kv_wr_data = 32'h11;
    tick();
    bus.clear_req = 1'b0; bus.kv_wr_en = 1'b0;
    n_cmp++; if (bus.kv_wr_err !== 1'b1) begin n_bad++; $display("FAIL clear_same_cycle_wr got %b exp 1", bus.kv_wr_err); end
    while (bus.busy && cnt < 100) begin
      cnt++;
      if (cnt == 3) begin wr(5'd1, 4'd0, 32'h11); w_during = werr; end
      else if (cnt == 6) begin rd(5'd3, 4'd0); r_during = rerr; end
      else tick();
    end
    n_cmp++; if (cnt !== 24) begin n_bad++; $display("FAIL clear_busy_cycles got %0d exp 24", cnt); end
    n_cmp++; if ({w_during, r_during} !== 2'b11) begin n_bad++; $display("FAIL clear_busy_access got %b exp 11", {w_during, r_during}); end
    n_cmp++; if (bus.entry_valid !== 24'h0) begin n_bad++; $display("FAIL clear_valid got %h exp 0", bus.entry_valid); end
    rd(5'd0, 4'd0);
    n_cmp++; if ({rerr, rdat} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL clear_rd got %b/%h exp 1/0", rerr, rdat); end
    wr(5'd1, 4'd0, 32'h11);
    n_cmp++; if (werr !== 1'b0) begin n_bad++; $display("FAIL clear_after_wr got %b exp 0", werr); end
    wr(5'd7, 4'd0, 32'h70);
    n_cmp++; if (werr !== 1'b0) begin n_bad++; $display("FAIL clear_unpoison got %b exp 0", werr); end
  endtask

  task automatic test_restart;
    int cnt = 0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    repeat (4) tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      tick();
    end
    n_cmp++; if (cnt !== 24) begin n_bad++; $display("FAIL restart_busy_cycles got %0d exp 24", cnt); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.kv_wr_en = 1'b0; bus.kv_wr_entry = '0; bus.kv_wr_offset = '0; bus.kv_wr_data = '0;
    bus.lock_wr = '0; bus.clear_req = 1'b0;
    bus.rd_en = 1'b0; bus.rd_entry = '0; bus.rd_offset = '0;
    test_reset();
    test_fill();
    test_poison();
    test_lock();
    test_range();
    test_rewrite();
    test_same_cycle();
    test_back_to_back();
    test_clear();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
